// File: rtl/alu_arbiter.sv
// Round-robin arbiter and sequencer that shares one combinational ALU between
// two requesters: latches the winner's operands, waits SETTLE_CYCLES, and returns q.
module alu_arbiter #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [1:0] op0,
    input  logic [2:0] a0,
    input  logic [2:0] b0,
    input  logic       req1,
    input  logic [1:0] op1,
    input  logic [2:0] a1,
    input  logic [2:0] b1,
    output logic [1:0] alu_sel,
    output logic [2:0] alu_a,
    output logic [2:0] alu_b,
    input  logic [3:0] alu_q,
    output logic [3:0] result,
    output logic       done0,
    output logic       done1,
    output logic       busy,
    output logic       owner
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES);

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       last, last_nxt;     // id of the most recent grant
    logic       gid;
    logic [1:0] sel_nxt;
    logic [2:0] a_nxt, b_nxt;
    logic [3:0] result_nxt;
    logic       done0_nxt, done1_nxt, owner_nxt;

    assign busy = (state != IDLE);

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned; otherwise synthesis infers a latch to hold its value.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        last_nxt   = last;
        owner_nxt  = owner;
        sel_nxt    = alu_sel;
        a_nxt      = alu_a;
        b_nxt      = alu_b;
        result_nxt = result;
        done0_nxt  = 1'b0;
        done1_nxt  = 1'b0;
        gid        = 1'b0;

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    // On a tie the requester not served last wins.
                    gid       = (req0 && req1) ? ~last : req1;
                    sel_nxt   = gid ? op1 : op0;
                    a_nxt     = gid ? a1 : a0;
                    b_nxt     = gid ? b1 : b0;
                    owner_nxt = gid;
                    last_nxt  = gid;
                    cnt_nxt   = CNT_INIT;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    result_nxt = alu_q;
                    done0_nxt  = ~owner;
                    done1_nxt  = owner;
                    state_nxt  = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            last    <= 1'b1;        // makes requester 0 win the first tie
            owner   <= 1'b0;
            alu_sel <= 2'd0;
            alu_a   <= 3'd0;
            alu_b   <= 3'd0;
            result  <= 4'd0;
            done0   <= 1'b0;
            done1   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            last    <= last_nxt;
            owner   <= owner_nxt;
            alu_sel <= sel_nxt;
            alu_a   <= a_nxt;
            alu_b   <= b_nxt;
            result  <= result_nxt;
            done0   <= done0_nxt;
            done1   <= done1_nxt;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: two instances (settle 1 and 4) driven by directed and
// random stimulus, checked against a transaction-schedule model of the arbiter.
module tb_alu_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       req0[2], req1[2];
    logic [1:0] op0[2], op1[2];
    logic [2:0] a0[2], b0[2], a1[2], b1[2];
    logic [1:0] alu_sel[2];
    logic [2:0] alu_a[2], alu_b[2];
    logic [3:0] alu_q[2], result[2];
    logic       done0[2], done1[2], busy[2], owner[2];

    int total = 0;
    int bad   = 0;

    // Stand-in for the shared ALU: add, subtract, and, or.
    function automatic logic [3:0] alu_f(logic [1:0] s, logic [2:0] a, logic [2:0] b);
        case (s)
            2'd0:    return 4'(a) + 4'(b);
            2'd1:    return 4'(a) - 4'(b);
            2'd2:    return {1'b0, a & b};
            default: return {1'b0, a | b};
        endcase
    endfunction

    assign alu_q[0] = alu_f(alu_sel[0], alu_a[0], alu_b[0]);
    assign alu_q[1] = alu_f(alu_sel[1], alu_a[1], alu_b[1]);

    alu_arbiter #(.SETTLE_CYCLES(1)) dut_s1 (
        .clk(clk), .rst(rst),
        .req0(req0[0]), .op0(op0[0]), .a0(a0[0]), .b0(b0[0]),
        .req1(req1[0]), .op1(op1[0]), .a1(a1[0]), .b1(b1[0]),
        .alu_sel(alu_sel[0]), .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_q(alu_q[0]),
        .result(result[0]), .done0(done0[0]), .done1(done1[0]), .busy(busy[0]), .owner(owner[0])
    );

    alu_arbiter #(.SETTLE_CYCLES(4)) dut_s4 (
        .clk(clk), .rst(rst),
        .req0(req0[1]), .op0(op0[1]), .a0(a0[1]), .b0(b0[1]),
        .req1(req1[1]), .op1(op1[1]), .a1(a1[1]), .b1(b1[1]),
        .alu_sel(alu_sel[1]), .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_q(alu_q[1]),
        .result(result[1]), .done0(done0[1]), .done1(done1[1]), .busy(busy[1]), .owner(owner[1])
    );

    // Model: each operation is a schedule (grant edge g, result edge g+S, free at g+S+2).
    int          settle[2] = '{1, 4};
    int          n = 0;
    int          m_free[2], m_done[2];
    logic        m_last[2], m_owner[2];
    logic [1:0]  m_sel[2];
    logic [2:0]  m_a[2], m_b[2];
    logic [3:0]  m_res[2], m_pend[2];
    logic [15:0] m_exp[2];

    function automatic logic [15:0] act_vec(int d);
        return {alu_sel[d], alu_a[d], alu_b[d], result[d], done0[d], done1[d], busy[d], owner[d]};
    endfunction

    task automatic model_edge(int d);
        logic w;
        logic dn;
        if (rst) begin
            m_free[d] = n + 1; m_done[d] = -10; m_last[d] = 1'b1; m_owner[d] = 1'b0;
            m_sel[d] = '0; m_a[d] = '0; m_b[d] = '0; m_res[d] = '0;
        end else begin
            if (n == m_done[d]) m_res[d] = m_pend[d];
            if (n >= m_free[d] && (req0[d] || req1[d])) begin
                w = (req0[d] && req1[d]) ? !m_last[d] : req1[d];
                m_sel[d]   = w ? op1[d] : op0[d];
                m_a[d]     = w ? a1[d] : a0[d];
                m_b[d]     = w ? b1[d] : b0[d];
                m_owner[d] = w;
                m_last[d]  = w;
                m_pend[d]  = alu_f(m_sel[d], m_a[d], m_b[d]);
                m_done[d]  = n + settle[d];
                m_free[d]  = n + settle[d] + 2;
            end
        end
        dn = (n == m_done[d]);
        m_exp[d] = {m_sel[d], m_a[d], m_b[d], m_res[d], dn && !m_owner[d], dn && m_owner[d],
                    (n + 1 < m_free[d]), m_owner[d]};
    endtask

    task automatic tick();
        model_edge(0);
        model_edge(1);
        @(posedge clk);
        n++;
        #1;
    endtask

    task automatic idle_inputs(int d);
        req0[d] = 0; req1[d] = 0; op0[d] = 0; op1[d] = 0;
        a0[d] = 0; b0[d] = 0; a1[d] = 0; b1[d] = 0;
    endtask

    task automatic test_reset();
        rst = 1; tick(); tick();
        for (int d = 0; d < 2; d++) begin
            total++;
            if (act_vec(d) !== 16'h0) begin
                bad++; $display("FAIL reset d%0d got=%h want=0000", d, act_vec(d));
            end
        end
        rst = 0;
    endtask

    task automatic test_single_req0();
        req0[0] = 1; op0[0] = 2'b00; a0[0] = 3; b0[0] = 5;
        tick();
        total++;
        if ({alu_sel[0], alu_a[0], alu_b[0], busy[0]} !== {2'b00, 3'd3, 3'd5, 1'b1}) begin
            bad++; $display("FAIL req0_grant got=%b_%0d_%0d_%b want=00_3_5_1",
                            alu_sel[0], alu_a[0], alu_b[0], busy[0]);
        end
        req0[0] = 0; a0[0] = 7; b0[0] = 7;
        tick();
        total++;
        if ({result[0], done0[0], done1[0], busy[0]} !== {4'b1000, 1'b1, 1'b0, 1'b1}) begin
            bad++; $display("FAIL req0_done got=%b_%b%b_%b want=1000_10_1",
                            result[0], done0[0], done1[0], busy[0]);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (act_vec(0) !== m_exp[0] || done0[0] !== 1'b0 || busy[0] !== 1'b0) begin
                bad++; $display("FAIL req0_after i=%0d got=%h want=%h", i, act_vec(0), m_exp[0]);
            end
        end
    endtask

    task automatic test_single_req1();
        bit seen;
        seen = 0;
        req1[0] = 1; op1[0] = 2'b01; a1[0] = 5; b1[0] = 3;
        tick();
        req1[0] = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done1[0]) seen = 1;
            total++;
            if (act_vec(0) !== m_exp[0] || done0[0] !== 1'b0) begin
                bad++; $display("FAIL req1_seq i=%0d got=%h want=%h", i, act_vec(0), m_exp[0]);
            end
        end
        total++;
        if ({seen, result[0], owner[0]} !== {1'b1, 4'b0010, 1'b1}) begin
            bad++; $display("FAIL req1_result got=%b_%b_%b want=1_0010_1", seen, result[0], owner[0]);
        end
    endtask

    task automatic test_tie_alternate();
        int k, prev;
        k = 0; prev = 0;
        req0[0] = 1; op0[0] = 2'b10; a0[0] = 6; b0[0] = 3;
        req1[0] = 1; op1[0] = 2'b11; a1[0] = 4; b1[0] = 1;
        for (int i = 0; i < 14; i++) begin
            tick();
            total++;
            if (act_vec(0) !== m_exp[0]) begin
                bad++; $display("FAIL tie_seq i=%0d got=%h want=%h", i, act_vec(0), m_exp[0]);
            end
            if (done0[0] || done1[0]) begin
                total++;
                if ({done1[0], owner[0]} !== {k[0], k[0]} || (k > 0 && n - prev != 3)) begin
                    bad++; $display("FAIL tie_done k=%0d got_owner=%b gap=%0d want_owner=%0d gap=3",
                                    k, owner[0], n - prev, k % 2);
                end
                prev = n; k++;
            end
        end
        total++;
        if (k < 4) begin
            bad++; $display("FAIL tie_count got=%0d want>=4", k);
        end
        idle_inputs(0);
        tick(); tick(); tick();
    endtask

    task automatic test_settle4_freeze();
        int g;
        req0[1] = 1; op0[1] = 2'b00; a0[1] = 2; b0[1] = 6;
        tick();
        g = n;
        req0[1] = 0;
        for (int i = 0; i < 6; i++) begin
            a0[1] = 3'($urandom); b0[1] = 3'($urandom);
            tick();
            total++;
            if (act_vec(1) !== m_exp[1] || alu_a[1] !== 3'd2 || alu_b[1] !== 3'd6 ||
                done0[1] !== (n - g == 4)) begin
                bad++; $display("FAIL settle4 i=%0d got=%h a=%0d b=%0d want=%h a=2 b=6",
                                i, act_vec(1), alu_a[1], alu_b[1], m_exp[1]);
            end
        end
        total++;
        if (result[1] !== 4'd8) begin
            bad++; $display("FAIL settle4_result got=%0d want=8", result[1]);
        end
    endtask

    task automatic test_reset_mid_wait();
        req1[1] = 1; op1[1] = 2'b10; a1[1] = 7; b1[1] = 5;
        tick();
        req1[1] = 0;
        tick(); tick();
        rst = 1;
        tick();
        rst = 0;
        total++;
        if (act_vec(1) !== 16'h0) begin
            bad++; $display("FAIL abort_zero got=%h want=0000", act_vec(1));
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (done1[1] !== 1'b0 || act_vec(1) !== m_exp[1]) begin
                bad++; $display("FAIL abort_quiet i=%0d got=%h want=%h", i, act_vec(1), m_exp[1]);
            end
        end
        req0[1] = 1; req1[1] = 1;
        tick();
        req0[1] = 0; req1[1] = 0;
        total++;
        if ({owner[1], busy[1]} !== 2'b01) begin
            bad++; $display("FAIL abort_tie got_owner=%b busy=%b want_owner=0 busy=1", owner[1], busy[1]);
        end
        for (int i = 0; i < 7; i++) tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            for (int d = 0; d < 2; d++) begin
                req0[d] = ($urandom_range(0, 2) != 0); req1[d] = ($urandom_range(0, 2) != 0);
                op0[d] = 2'($urandom); op1[d] = 2'($urandom);
                a0[d] = 3'($urandom); b0[d] = 3'($urandom);
                a1[d] = 3'($urandom); b1[d] = 3'($urandom);
            end
            tick();
            for (int d = 0; d < 2; d++) begin
                total++;
                if (act_vec(d) !== m_exp[d] || (done0[d] && done1[d])) begin
                    bad++; $display("FAIL random i=%0d d=%0d got=%h want=%h", i, d, act_vec(d), m_exp[d]);
                end
            end
        end
    endtask

    initial begin
        rst = 1;
        for (int d = 0; d < 2; d++) begin
            idle_inputs(d);
            m_free[d] = 0; m_done[d] = -10; m_last[d] = 1; m_owner[d] = 0;
            m_sel[d] = 0; m_a[d] = 0; m_b[d] = 0; m_res[d] = 0; m_pend[d] = 0; m_exp[d] = 0;
        end
        @(negedge clk);
        test_reset();
        test_single_req0();
        test_single_req1();
        test_tie_alternate();
        test_settle4_freeze();
        test_reset_mid_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
